// File: rtl/md5_stream_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md5_stream_padder: byte stream in, MD5-padded 512-bit blocks out. Rev 1.0  |
// +----------------------------------------------------------------------------+
module md5_stream_padder #(
  parameter int IN_BYTES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*IN_BYTES-1:0]         in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
  input  logic                          in_last,
  output logic                          block_valid,
  input  logic                          block_ready,
  output logic [511:0]                  block,
  output logic                          block_last,
  output logic                          busy
);

  generate
    if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4 || IN_BYTES == 8)) begin : g_bad_in_bytes
      $error("md5_stream_padder: IN_BYTES must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    OUT   = 2'd1,
    EXTRA = 2'd2
  } state_t;

  state_t       state_q;
  logic [511:0] block_q;
  logic [511:0] block_d;
  logic [511:0] extra_blk;
  logic [5:0]   ptr_q;
  logic [6:0]   ptr_sum;
  logic [63:0]  len_q;
  logic [63:0]  len_d;
  logic [3:0]   cnt;
  logic [5:0]   idx;
  logic         in_ready_q;
  logic         block_valid_q;
  logic         block_last_q;
  logic         busy_q;
  logic         extra_q;
  logic         marker_q;
  logic         accept;

  assign accept      = in_valid && in_ready_q && (state_q == FILL);
  assign in_ready    = in_ready_q;
  assign block_valid = block_valid_q;
  assign block       = block_q;
  assign block_last  = block_last_q;
  assign busy        = busy_q;

  always_comb begin
    cnt = 4'(IN_BYTES);
    if (in_last && (4'(in_nbytes) < 4'(IN_BYTES))) begin
      cnt = 4'(in_nbytes);
    end
    ptr_sum = {1'b0, ptr_q} + 7'(cnt);
    len_d   = len_q + {57'd0, cnt, 3'd0};
  end

  // Beat bytes land on a cleared block, so dropped and fill bytes stay zero.
  always_comb begin
    block_d = block_q;
    idx     = 6'd0;
    for (int k = 0; k < IN_BYTES; k++) begin
      if (k < int'(cnt)) begin
        idx = 6'(ptr_q + 6'(k));
        block_d[8*int'(idx) +: 8] = in_data[8*k +: 8];
      end
    end
    if (in_last && !ptr_sum[6]) begin
      block_d[8*int'(ptr_sum[5:0]) +: 8] = 8'h80;
      if (ptr_sum <= 7'd55) begin
        block_d[511:448] = len_d;
      end
    end
  end

  always_comb begin
    extra_blk          = '0;
    extra_blk[511:448] = len_q;
    if (!marker_q) begin
      extra_blk[7:0] = 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      block_q       <= '0;
      ptr_q         <= '0;
      len_q         <= '0;
      in_ready_q    <= 1'b0;
      block_valid_q <= 1'b0;
      block_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      extra_q       <= 1'b0;
      marker_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            busy_q  <= 1'b1;
            block_q <= block_d;
            len_q   <= len_d;
            ptr_q   <= ptr_sum[5:0];
            if (in_last) begin
              state_q       <= OUT;
              in_ready_q    <= 1'b0;
              block_valid_q <= 1'b1;
              block_last_q  <= (ptr_sum <= 7'd55);
              extra_q       <= (ptr_sum > 7'd55);
              marker_q      <= !ptr_sum[6];
            end else if (ptr_sum[6]) begin
              state_q       <= OUT;
              in_ready_q    <= 1'b0;
              block_valid_q <= 1'b1;
              block_last_q  <= 1'b0;
              extra_q       <= 1'b0;
            end
          end
        end
        // EXTRA presents the trailing length-only block loaded at the previous handshake.
        OUT, EXTRA: begin
          if (block_ready) begin
            if (extra_q) begin
              state_q      <= EXTRA;
              block_q      <= extra_blk;
              block_last_q <= 1'b1;
              extra_q      <= 1'b0;
            end else begin
              state_q       <= FILL;
              block_q       <= '0;
              block_valid_q <= 1'b0;
              block_last_q  <= 1'b0;
              in_ready_q    <= 1'b1;
              if (block_last_q) begin
                len_q    <= '0;
                ptr_q    <= '0;
                busy_q   <= 1'b0;
                marker_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md5_stream_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_md5_stream_padder: padding model + scoreboard for IN_BYTES=1 and 4.     |
// +----------------------------------------------------------------------------+
module tb_md5_stream_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_in_last, a_block_valid, a_block_ready, a_block_last, a_busy;
  logic [7:0]   a_in_data;
  logic [0:0]   a_in_nbytes;
  logic [511:0] a_block;

  logic         b_in_valid, b_in_ready, b_in_last, b_block_valid, b_block_ready, b_block_last, b_busy;
  logic [31:0]  b_in_data;
  logic [2:0]   b_in_nbytes;
  logic [511:0] b_block;

  md5_stream_padder #(.IN_BYTES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_nbytes(a_in_nbytes), .in_last(a_in_last),
    .block_valid(a_block_valid), .block_ready(a_block_ready), .block(a_block),
    .block_last(a_block_last), .busy(a_busy)
  );

  md5_stream_padder #(.IN_BYTES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_nbytes(b_in_nbytes), .in_last(b_in_last),
    .block_valid(b_block_valid), .block_ready(b_block_ready), .block(b_block),
    .block_last(b_block_last), .busy(b_busy)
  );

  typedef struct {
    logic [511:0] blk;
    logic         last;
    logic         imm;
  } exp_t;

  typedef struct {
    int          len;
    int          kind;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w14;
  } vec_t;

  exp_t         exp_a[$];
  exp_t         exp_b[$];
  exp_t         ea, eb;
  byte unsigned msg[$];
  int           errors = 0;
  int           checks = 0;
  int           hs_a = 0;
  int           hs_b = 0;
  logic         imm_a = 1'b0;
  logic         imm_b = 1'b0;
  logic [511:0] last_blk_a = '0;
  logic [511:0] last_blk_b = '0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
  task automatic model_push(input bit to_b);
    byte unsigned p[$];
    logic [63:0]  bits;
    exp_t         e;
    int           nblk;
    bits = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[8*i +: 8] = p[64*b + i];
      e.last = (b == nblk - 1);
      e.imm  = e.last && (b > 0) && (64*b >= msg.size());
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (imm_a) begin
      imm_a = 1'b0;
      chk("a_extra_latency", 512'(a_block_valid), 512'(1));
    end
    if (imm_b) begin
      imm_b = 1'b0;
      chk("b_extra_latency", 512'(b_block_valid), 512'(1));
    end
    if (rst_n && a_block_valid && a_block_ready) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_block: got %h want none", a_block);
      end else begin
        ea = exp_a.pop_front();
        chk("a_block", a_block, ea.blk);
        chk("a_block_last", 512'(a_block_last), 512'(ea.last));
        imm_a = (exp_a.size() > 0) && exp_a[0].imm;
        last_blk_a = a_block;
        hs_a++;
      end
    end
    if (rst_n && b_block_valid && b_block_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_block: got %h want none", b_block);
      end else begin
        eb = exp_b.pop_front();
        chk("b_block", b_block, eb.blk);
        chk("b_block_last", 512'(b_block_last), 512'(eb.last));
        imm_b = (exp_b.size() > 0) && exp_b[0].imm;
        last_blk_b = b_block;
        hs_b++;
      end
    end
  end

  task automatic put_a(input logic [7:0] d, input logic last, input logic [0:0] nb);
    int t = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_last = last; a_in_nbytes = nb;
    while (!a_in_ready && t < 300) begin @(negedge clk); t++; end
    if (!a_in_ready) fail_now("a_in_ready_wait");
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = 8'h00;
  endtask

  task automatic put_b(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_last = last; b_in_nbytes = nb;
    while (!b_in_ready && t < 300) begin @(negedge clk); t++; end
    if (!b_in_ready) fail_now("b_in_ready_wait");
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = 32'h0;
  endtask

  task automatic send_a(input bit push);
    if (push) model_push(1'b0);
    if (msg.size() == 0) put_a(8'h00, 1'b1, 1'b0);
    else for (int i = 0; i < msg.size(); i++) put_a(msg[i], (i == msg.size() - 1), 1'b1);
  endtask

  task automatic drain_a();
    int t = 0;
    while (exp_a.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (exp_a.size() != 0) fail_now("a_drain");
    @(negedge clk);
    chk("a_busy_idle", 512'(a_busy), 512'(0));
    chk("a_in_ready_idle", 512'(a_in_ready), 512'(1));
  endtask

  task automatic drain_b();
    int t = 0;
    while (exp_b.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (exp_b.size() != 0) fail_now("b_drain");
    @(negedge clk);
    chk("b_busy_idle", 512'(b_busy), 512'(0));
    chk("b_in_ready_idle", 512'(b_in_ready), 512'(1));
  endtask

  task automatic wait_valid_a();
    int t = 0;
    while (!a_block_valid && t < 50) begin @(negedge clk); t++; end
    if (!a_block_valid) fail_now("a_block_valid_wait");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   h0;
    vecs[0] = '{3,   0, 1, 32'h80636261, 32'h00000018};
    vecs[1] = '{0,   0, 1, 32'h00000080, 32'h00000000};
    vecs[2] = '{56,  1, 2, 32'h00000000, 32'h000001C0};
    vecs[3] = '{64,  2, 2, 32'h00000080, 32'h00000200};
    vecs[4] = '{55,  1, 1, 32'h41414141, 32'h000001B8};
    vecs[5] = '{63,  2, 2, 32'h00000000, 32'h000001F8};
    vecs[6] = '{65,  2, 2, 32'h00008040, 32'h00000208};
    vecs[7] = '{120, 0, 3, 32'h00000000, 32'h000003C0};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_nbytes = '0; a_in_last = 1'b0; a_block_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_nbytes = '0; b_in_last = 1'b0; b_block_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(a_in_ready), 512'(0));
    chk("rst_block_valid", 512'(a_block_valid), 512'(0));
    chk("rst_block_last", 512'(a_block_last), 512'(0));
    chk("rst_block", a_block, 512'(0));
    chk("rst_busy", 512'(a_busy), 512'(0));
    chk("rst_b_in_ready", 512'(b_in_ready), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(a_in_ready), 512'(1));
    chk("post_rst_b_in_ready", 512'(b_in_ready), 512'(1));

    for (int v = 0; v < 8; v++) begin
      msg = {};
      for (int i = 0; i < vecs[v].len; i++) begin
        case (vecs[v].kind)
          0:       msg.push_back(8'(8'h61 + i));
          1:       msg.push_back(8'h41);
          default: msg.push_back(8'(i));
        endcase
      end
      h0 = hs_a;
      send_a(1'b1);
      drain_a();
      chk($sformatf("v%0d_nblk", v), 512'(hs_a - h0), 512'(vecs[v].nblk));
      chk($sformatf("v%0d_w0", v), 512'(last_blk_a[31:0]), 512'(vecs[v].w0));
      chk($sformatf("v%0d_w14", v), 512'(last_blk_a[479:448]), 512'(vecs[v].w14));
    end

    // Output stall: block and flags must hold while block_ready is low.
    a_block_ready = 1'b0;
    msg = {8'h61, 8'h62, 8'h63};
    send_a(1'b1);
    wait_valid_a();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_block", a_block, exp_a[0].blk);
      chk("stall_last", 512'(a_block_last), 512'(1));
      chk("stall_valid", 512'(a_block_valid), 512'(1));
      chk("stall_in_ready", 512'(a_in_ready), 512'(0));
    end
    a_block_ready = 1'b1;
    drain_a();

    // Reset with a block pending and unacknowledged: it must vanish.
    a_block_ready = 1'b0;
    msg = {8'h78, 8'h79};
    send_a(1'b0);
    wait_valid_a();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_block_ready = 1'b1;
    chk("rst_hs_valid", 512'(a_block_valid), 512'(0));
    chk("rst_hs_busy", 512'(a_busy), 512'(0));
    chk("rst_hs_block", a_block, 512'(0));
    @(negedge clk);

    // Reset mid-message during FILL.
    put_a(8'h11, 1'b0, 1'b1);
    put_a(8'h22, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_valid", 512'(a_block_valid), 512'(0));
    chk("rst_mid_busy", 512'(a_busy), 512'(0));
    chk("rst_mid_in_ready", 512'(a_in_ready), 512'(0));
    @(negedge clk);
    chk("rst_mid_in_ready_after", 512'(a_in_ready), 512'(1));
    msg = {8'h61, 8'h62, 8'h63};
    h0 = hs_a;
    send_a(1'b1);
    drain_a();
    chk("post_rst_abc_nblk", 512'(hs_a - h0), 512'(1));
    chk("post_rst_abc_w0", 512'(last_blk_a[31:0]), 512'(32'h80636261));

    // 4-byte beats: partial last beat with a non-zero dropped byte.
    msg = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    model_push(1'b1);
    put_b(32'h64636261, 1'b0, 3'd0);
    put_b(32'hAA676665, 1'b1, 3'd3);
    drain_b();
    chk("b4_w0", 512'(last_blk_b[31:0]), 512'(32'h64636261));
    chk("b4_w1", 512'(last_blk_b[63:32]), 512'(32'h80676665));
    chk("b4_w14", 512'(last_blk_b[479:448]), 512'(32'h00000038));

    // in_nbytes above the beat width is clamped to a full beat.
    msg = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    model_push(1'b1);
    put_b(32'h64636261, 1'b0, 3'd0);
    put_b(32'h68676665, 1'b1, 3'd7);
    drain_b();
    chk("b8_w2", 512'(last_blk_b[95:64]), 512'(32'h00000080));
    chk("b8_w14", 512'(last_blk_b[479:448]), 512'(32'h00000040));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
